// File: rtl/alu_mc.sv
// Multi-cycle ALU execute unit: single-cycle logic/arith ops plus iterative
// shift-add multiply and restoring unsigned divide, with valid/ready on both sides.
module alu_mc #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   control,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         err
);

  localparam int            CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_UDIV  = 4'b1001;
  localparam logic [3:0] OP_UREM  = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // Captured operation and iteration registers: acc holds the product
  // accumulator (MUL) or partial remainder (UDIV/UREM); sa is the shifting
  // multiplicand or dividend/quotient; sb the multiplier or divisor.
  logic [3:0]    op;
  logic [N-1:0]  acc;
  logic [N-1:0]  sa;
  logic [N-1:0]  sb;

  logic [N-1:0]  acc_nx;
  logic [N-1:0]  sa_nx;
  logic [N-1:0]  sb_nx;
  logic [N-1:0]  calc_res;
  logic [N:0]    shifted;
  logic [N-1:0]  diff;

  logic [N-1:0]  imm_res;
  logic          imm_err;
  logic          start_calc;
  logic          accept;

  function automatic logic [N-1:0] single_op(input logic [3:0]   c,
                                             input logic [N-1:0] x,
                                             input logic [N-1:0] y);
    logic [N-1:0] r;
    case (c)
      OP_AND:   r = x & y;
      OP_OR:    r = x | y;
      OP_ADD:   r = x + y;
      OP_SUB:   r = x - y;
      OP_PASSB: r = y;
      OP_NOR:   r = ~(x | y);
      default:  r = '0;
    endcase
    return r;
  endfunction

  assign accept     = (state == IDLE) && in_valid && in_ready;
  assign start_calc = (control == OP_MUL) ||
                      (((control == OP_UDIV) || (control == OP_UREM)) && (b != '0));

  // Immediate result for everything that finishes on the accepting edge,
  // including divide-by-zero which bypasses the iteration entirely.
  always_comb begin
    imm_res = single_op(control, a, b);
    imm_err = 1'b0;
    case (control)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASSB, OP_NOR: imm_err = 1'b0;
      OP_UDIV: begin
        imm_res = '1;
        imm_err = 1'b1;
      end
      OP_UREM: begin
        imm_res = a;
        imm_err = 1'b1;
      end
      OP_MUL:  imm_err = 1'b0;
      default: imm_err = 1'b1;
    endcase
  end

  // One iteration step: shift-add multiply or one restoring-division bit.
  always_comb begin
    acc_nx  = acc;
    sa_nx   = sa;
    sb_nx   = sb;
    shifted = '0;
    diff    = '0;
    if (op == OP_MUL) begin
      if (sb[0]) acc_nx = acc + sa;
      sa_nx = sa << 1;
      sb_nx = sb >> 1;
    end else begin
      shifted = {acc, sa[N-1]};
      diff    = shifted[N-1:0] - sb;
      if (shifted >= {1'b0, sb}) begin
        acc_nx = diff;
        sa_nx  = {sa[N-2:0], 1'b1};
      end else begin
        acc_nx = shifted[N-1:0];
        sa_nx  = {sa[N-2:0], 1'b0};
      end
    end
    calc_res = (op == OP_UDIV) ? sa_nx : acc_nx;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op  <= control;
      acc <= '0;
      sa  <= a;
      sb  <= b;
    end else if (state == CALC) begin
      acc <= acc_nx;
      sa  <= sa_nx;
      sb  <= sb_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            in_ready <= 1'b0;
            cnt      <= '0;
            if (start_calc) begin
              state <= CALC;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= imm_res;
              zero      <= (imm_res == '0);
              err       <= imm_err;
            end
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= calc_res;
            zero      <= (calc_res == '0);
            err       <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: a 64-bit and an 8-bit instance driven with
// hand-computed vectors, checking result, flags, latency and handshake.
module tb_alu_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        iv64, ir64, ov64, ordy64, z64, e64;
  logic [63:0] a64, b64, r64;
  logic [3:0]  c64;
  logic        iv8, ir8, ov8, ordy8, z8, e8;
  logic [7:0]  a8, b8, r8;
  logic [3:0]  c8;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [3:0] AND_C = 4'b0000, OR_C = 4'b0001, ADD_C = 4'b0010,
                         SUB_C = 4'b0110, PSB_C = 4'b0111, NOR_C = 4'b1100,
                         MUL_C = 4'b1000, DIV_C = 4'b1001, REM_C = 4'b1010,
                         BAD_C = 4'b1111;

  alu_mc #(.N(64)) u64 (
    .clk(clk), .reset(reset), .in_valid(iv64), .in_ready(ir64),
    .a(a64), .b(b64), .control(c64), .out_valid(ov64), .out_ready(ordy64),
    .result(r64), .zero(z64), .err(e64)
  );

  alu_mc #(.N(8)) u8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .control(c8), .out_valid(ov8), .out_ready(ordy8),
    .result(r8), .zero(z8), .err(e8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Present an op, wait for acceptance, scramble the inputs, then count
  // edges until out_valid is first seen.
  task automatic run_op(input bit w8, input logic [3:0] c, input logic [63:0] x, input logic [63:0] y,
                        output logic [63:0] r, output logic z, output logic e,
                        output int lat, output bit rdy_busy);
    int guard;
    guard = 0;
    @(negedge clk);
    if (w8) begin
      a8 = x[7:0]; b8 = y[7:0]; c8 = c; iv8 = 1'b1;
    end else begin
      a64 = x; b64 = y; c64 = c; iv64 = 1'b1;
    end
    while (!(w8 ? ir8 : ir64) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    iv8 = 1'b0; iv64 = 1'b0;
    a8 = ~a8; b8 = ~b8; c8 = ~c8;
    a64 = ~a64; b64 = ~b64; c64 = ~c64;
    rdy_busy = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!(w8 ? ov8 : ov64) && lat < 200) begin
      if (w8 ? ir8 : ir64) rdy_busy = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (w8 ? ir8 : ir64) rdy_busy = 1'b1;
    r = w8 ? {56'd0, r8} : r64;
    z = w8 ? z8 : z64;
    e = w8 ? e8 : e64;
  endtask

  task automatic expect_op(input string tag, input bit w8, input logic [3:0] c,
                           input logic [63:0] x, input logic [63:0] y,
                           input logic [63:0] er, input logic ez, input logic ee, input int elat);
    logic [63:0] r;
    logic        z, e;
    int          lat;
    bit          busy;
    run_op(w8, c, x, y, r, z, e, lat, busy);
    check({tag, "_res"}, r, er);
    check({tag, "_zero"}, {63'd0, z}, {63'd0, ez});
    check({tag, "_err"}, {63'd0, e}, {63'd0, ee});
    check({tag, "_lat"}, 64'(lat), 64'(elat));
    check({tag, "_inrdy_low"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit saw;
    reset = 1'b0;
    iv64 = 1'b0; ordy64 = 1'b1; a64 = '0; b64 = '0; c64 = '0;
    iv8  = 1'b0; ordy8  = 1'b1; a8  = '0; b8  = '0; c8  = '0;

    repeat (3) @(negedge clk);
    check("rst_in_ready",  {63'd0, ir64}, 64'd0);
    check("rst_out_valid", {63'd0, ov64}, 64'd0);
    check("rst_result",    r64, 64'd0);
    check("rst_zero",      {63'd0, z64}, 64'd0);
    check("rst_err",       {63'd0, e64}, 64'd0);
    check("rst_in_ready8", {63'd0, ir8}, 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", {63'd0, ir64}, 64'd1);

    expect_op("add",  0, ADD_C, 64'd1, 64'd2, 64'd3, 1'b0, 1'b0, 1);
    expect_op("sub",  0, SUB_C, 64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1);
    expect_op("subz", 0, SUB_C, 64'd5, 64'd5, 64'd0, 1'b1, 1'b0, 1);
    expect_op("or",   0, OR_C,  64'd2, 64'd1, 64'd3, 1'b0, 1'b0, 1);
    expect_op("and",  0, AND_C, 64'd2, 64'd1, 64'd0, 1'b1, 1'b0, 1);
    expect_op("passb",0, PSB_C, 64'd9, 64'hDEAD, 64'hDEAD, 1'b0, 1'b0, 1);
    expect_op("nor",  0, NOR_C, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1);
    expect_op("ill",  0, BAD_C, 64'd5, 64'd5, 64'd0, 1'b1, 1'b1, 1);
    expect_op("postill", 0, ADD_C, 64'd1, 64'd1, 64'd2, 1'b0, 1'b0, 1);

    expect_op("mul1", 0, MUL_C, 64'h1_0000_0001, 64'd3, 64'h3_0000_0003, 1'b0, 1'b0, 65);
    expect_op("mul2", 0, MUL_C, 64'h8000_0000_0000_0000, 64'd2, 64'd0, 1'b1, 1'b0, 65);

    expect_op("div8",  1, DIV_C, 64'd200, 64'd7, 64'd28, 1'b0, 1'b0, 9);
    expect_op("rem8",  1, REM_C, 64'd200, 64'd7, 64'd4, 1'b0, 1'b0, 9);
    expect_op("div0",  1, DIV_C, 64'd42, 64'd0, 64'hFF, 1'b0, 1'b1, 1);
    expect_op("rem0",  1, REM_C, 64'd42, 64'd0, 64'd42, 1'b0, 1'b1, 1);
    expect_op("mul8a", 1, MUL_C, 64'd15, 64'd17, 64'hFF, 1'b0, 1'b0, 9);
    expect_op("mul8b", 1, MUL_C, 64'd16, 64'd16, 64'd0, 1'b1, 1'b0, 9);
    expect_op("rem8z", 1, REM_C, 64'd21, 64'd7, 64'd0, 1'b1, 1'b0, 9);

    // Backpressure: hold the MUL result while a new op is waiting.
    @(negedge clk);
    ordy64 = 1'b0;
    expect_op("bpmul", 0, MUL_C, 64'd7, 64'd6, 64'd42, 1'b0, 1'b0, 65);
    a64 = 64'd1; b64 = 64'd1; c64 = ADD_C; iv64 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_result", r64, 64'd42);
      check("bp_out_valid", {63'd0, ov64}, 64'd1);
      check("bp_in_ready", {63'd0, ir64}, 64'd0);
    end
    ordy64 = 1'b1;
    @(negedge clk);
    check("hs_out_valid", {63'd0, ov64}, 64'd0);
    check("hs_in_ready", {63'd0, ir64}, 64'd1);
    @(posedge clk);
    #1;
    iv64 = 1'b0;
    @(negedge clk);
    check("queued_valid", {63'd0, ov64}, 64'd1);
    check("queued_result", r64, 64'd2);

    // Reset in the middle of a 64-bit multiply.
    @(negedge clk);
    a64 = 64'h1234; b64 = 64'd5; c64 = MUL_C; iv64 = 1'b1;
    for (int g = 0; g < 10 && !ir64; g++) @(negedge clk);
    @(posedge clk);
    #1;
    iv64 = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("mrst_in_ready",  {63'd0, ir64}, 64'd0);
    check("mrst_out_valid", {63'd0, ov64}, 64'd0);
    check("mrst_result",    r64, 64'd0);
    check("mrst_zero",      {63'd0, z64}, 64'd0);
    check("mrst_err",       {63'd0, e64}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    saw = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (ov64) saw = 1'b1;
    end
    check("mrst_no_valid", {63'd0, saw}, 64'd0);
    expect_op("postrst", 0, ADD_C, 64'd4, 64'd4, 64'd8, 1'b0, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised successor to the processor's single-cycle combinational ALU.
- Same four-bit control encoding for AND/OR/ADD/SUB.
- Adds pass-B, NOR, iterative multiply, unsigned divide and remainder.
- Adds a valid/ready handshake on both sides, so it can act as an execute unit in a multi-cycle datapath.
- Results, `zero` and `err` are registered and held until consumed.

## Interface
- N, 64: operand/result width; legal values 8..64.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  operands and control presented.
- in_ready  out  1  unit can accept an operation.
- a  in  N  operand A.
- b  in  N  operand B.
- control  in  4  operation select.
- out_valid  out  1  result, zero and err are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  N  operation result.
- zero  out  1  result == 0.
- err  out  1  illegal opcode or divide by zero.

## Operation
- Control encoding, single-cycle class:
  - 0000 AND.
  - 0001 OR.
  - 0010 ADD (mod 2^N).
  - 0110 SUB (a−b mod 2^N).
  - 0111 pass b.
  - 1100 NOR.
- Control encoding, iterative class:
  - 1000 MUL: low N bits of a·b.
  - 1001 UDIV: unsigned a/b.
  - 1010 UREM: unsigned a mod b.
- Any other code: result 0, zero 1, err 1; treated as single-cycle.
- Handshake:
  - An operation is accepted on a rising edge with in_valid & in_ready.
  - a, b and control are captured at acceptance; later input changes have no effect.
- FSM states and transitions:
  - IDLE: in_ready=1. Accept of a single-cycle op → DONE. Accept of an iterative op → CALC.
  - CALC: in_ready=0. Iteration counter counts 0..N−1, one bit per cycle. At count N−1 → DONE.
  - DONE: out_valid=1, in_ready=0. If out_ready, → IDLE on the same edge.
- MUL algorithm: shift-add. Accumulator is N bits; product bits above N are discarded.
- UDIV/UREM algorithm: restoring division, quotient and remainder registers N bits each.
- Divide by zero (b==0), for UDIV and UREM:
  - Complete in 1 cycle (skip CALC).
  - UDIV returns all ones; UREM returns a.
  - err=1; zero is computed from result as usual.
- err=0 for all legal operations with a nonzero divisor.
- Output stability: result/zero/err are stable from out_valid rise until the handshake completes.
- No overlap: a new op cannot be accepted in the same cycle as output handshake; in_ready returns the cycle after.
- Reset:
  - While reset=0, all outputs are 0: in_ready=0, out_valid=0, result=0, zero=0, err=0.
  - FSM and counter go to IDLE/0.
  - Reset mid-CALC or in DONE discards the operation; no out_valid is produced for it.
  - First cycle after reset release: IDLE, in_ready=1.

## Timing
- Latency is counted from the accepting edge E to the edge at which out_valid is first seen high.
- Single-cycle ops, illegal ops and divide-by-zero: out_valid high after E+1.
- MUL/UDIV/UREM with b≠0: out_valid high after E+N+1 (N CALC cycles + DONE entry).
- Throughput with out_ready tied high:
  - Single-cycle: one op per 2 cycles.
  - Iterative: one op per N+2 cycles.
- Backpressure: DONE holds indefinitely while out_ready=0.
- in_valid while not ready is ignored; the producer must hold it.

## Test plan
- Single-cycle ops, N=64, out_ready=1:
  - ADD a=1, b=2 → result 3, zero 0.
  - SUB a=1, b=2 → result 0xFFFF_FFFF_FFFF_FFFF, zero 0.
  - SUB a=5, b=5 → result 0, zero 1.
  - OR a=2, b=1 → 3.
  - AND a=2, b=1 → 0, zero 1.
  - Each: out_valid exactly one edge after accept.
- Illegal control 1111 → result 0, zero 1, err 1, single-cycle latency; next op accepted normally with err 0.
- MUL, N=64:
  - a=0x1_0000_0001, b=3 → 0x3_0000_0003.
  - a=2^63, b=2 → 0, zero 1.
  - out_valid exactly 65 edges after accept; in_ready=0 throughout.
- UDIV/UREM, N=8:
  - a=200, b=7 → UDIV 28, UREM 4, latency 9.
  - b=0, a=42 → UDIV 0xFF err 1, UREM 42 err 1, latency 1.
- Backpressure: hold out_ready=0 for 10 cycles after a MUL completes.
  - result stable; in_valid with new op ignored.
  - Raise out_ready → handshake, then in_ready=1 next cycle.
- Reset mid-CALC: assert reset=0 at cycle 20 of a 64-bit MUL.
  - All outputs 0 on the next edge; no out_valid afterwards.
  - After release, ADD 4+4 → 8 with 1-cycle latency.
